// File: rtl/scr1_pipe_mprf_mp_pkg.sv
// Shared limits, index type and address-width helper for the multi-port register file.
package scr1_mprf_pkg;

  localparam int SCR1_MPRF_MAX_RD = 4;
  localparam int SCR1_MPRF_MAX_WR = 3;

  typedef logic [4:0] type_scr1_mprf_idx_t;

  // Address width for a register count; never narrower than one bit.
  function automatic int scr1_mprf_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/scr1_pipe_mprf_mp_if.sv
// Register-file access bundle between the EXU (master) and the register file (slave).
interface scr1_pipe_mprf_mp_if #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2
);

  logic [RD_PORTS*AW-1:0]   rd_addr;
  logic [RD_PORTS*XLEN-1:0] rd_data;
  logic [RD_PORTS-1:0]      rd_pend;
  logic [WR_PORTS-1:0]      wr_req;
  logic [WR_PORTS*AW-1:0]   wr_addr;
  logic [WR_PORTS*XLEN-1:0] wr_data;
  logic                     sb_set;
  logic [AW-1:0]            sb_addr;
  logic                     sb_flush;
  logic                     wr_coll;

  modport master (
    output rd_addr, wr_req, wr_addr, wr_data, sb_set, sb_addr, sb_flush,
    input  rd_data, rd_pend, wr_coll
  );

  modport slave (
    input  rd_addr, wr_req, wr_addr, wr_data, sb_set, sb_addr, sb_flush,
    output rd_data, rd_pend, wr_coll
  );

endinterface

// File: rtl/scr1_pipe_mprf_mp_wr_arb.sv
// Per-register write arbitration: the highest-index requesting port wins, x0 is never written,
// and two or more requests to the same nonzero register raise the collision bit.
module scr1_mprf_wr_arb
  import scr1_mprf_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int WR_PORTS = 2
) (
  input  logic [WR_PORTS-1:0]                           wr_req_i,
  input  logic [WR_PORTS*scr1_mprf_aw(NREGS)-1:0]       wr_addr_i,
  input  logic [WR_PORTS*XLEN-1:0]                      wr_data_i,
  output logic [NREGS-1:0]                              we_o,
  output logic [XLEN-1:0]                               data_o [NREGS],
  output logic                                          coll_o
);

  localparam int AW = scr1_mprf_aw(NREGS);

  // Ascending port scan, so a later match overwrites an earlier one and a repeat match flags a collision.
  always_comb begin
    we_o   = '0;
    coll_o = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      data_o[r] = '0;
    end
    for (int r = 1; r < NREGS; r++) begin
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_req_i[p] && (wr_addr_i[p*AW +: AW] == AW'(r))) begin
          if (we_o[r]) begin
            coll_o = 1'b1;
          end
          we_o[r]   = 1'b1;
          data_o[r] = wr_data_i[p*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/scr1_pipe_mprf_mp.sv
// Multi-port register file with same-cycle write bypass, per-register pending scoreboard
// and a registered write-collision flag; x0 reads as zero and is never pending.
module scr1_pipe_mprf_mp
  import scr1_mprf_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int RD_PORTS  = 2,
  parameter int WR_PORTS  = 2,
  parameter int BYPASS_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scr1_pipe_mprf_mp_if.slave   bus
);

  localparam int AW = scr1_mprf_aw(NREGS);

  logic [NREGS-1:0]  we;
  logic [XLEN-1:0]   wdata [NREGS];
  logic              coll;

  logic [XLEN-1:0]   regs_q [1:NREGS-1];
  logic [NREGS-1:1]  pend_q;
  logic [NREGS-1:1]  pend_d;
  logic              wr_coll_q;

  logic [XLEN-1:0]   regs_view [NREGS];
  logic [NREGS-1:0]  pend_view;
  logic [NREGS-1:0]  pend_next_view;
  logic [AW-1:0]     rd_idx;

  scr1_mprf_wr_arb #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .WR_PORTS (WR_PORTS)
  ) u_wr_arb (
    .wr_req_i  (bus.wr_req),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .we_o      (we),
    .data_o    (wdata),
    .coll_o    (coll)
  );

  // Scoreboard priority: flush over a new issue over a writeback clear over hold.
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < NREGS; r++) begin
      if (we[r]) begin
        pend_d[r] = 1'b0;
      end
      if (bus.sb_set && (bus.sb_addr == AW'(r))) begin
        pend_d[r] = 1'b1;
      end
      if (bus.sb_flush) begin
        pend_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 1; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      pend_q    <= '0;
      wr_coll_q <= 1'b0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (we[r]) begin
          regs_q[r] <= wdata[r];
        end
      end
      pend_q    <= pend_d;
      wr_coll_q <= coll;
    end
  end

  // Full-width views put a constant zero at index 0 so x0 needs no special read path.
  always_comb begin
    regs_view[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      regs_view[r] = regs_q[r];
    end
    pend_view      = {pend_q, 1'b0};
    pend_next_view = {pend_d, 1'b0};
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_pend = '0;
    rd_idx      = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_idx = bus.rd_addr[p*AW +: AW];
      if ((BYPASS_EN != 0) && we[rd_idx]) begin
        bus.rd_data[p*XLEN +: XLEN] = wdata[rd_idx];
        bus.rd_pend[p]              = pend_next_view[rd_idx];
      end else begin
        bus.rd_data[p*XLEN +: XLEN] = regs_view[rd_idx];
        bus.rd_pend[p]              = pend_view[rd_idx];
      end
    end
  end

  assign bus.wr_coll = wr_coll_q;

`ifdef SCR1_SIM_ENV
  for (genvar p = 0; p < WR_PORTS; p++) begin : g_sva_wr
    assert property (@(posedge clk) bus.wr_req[p] |->
      !$isunknown({bus.wr_addr[p*AW +: AW], bus.wr_data[p*XLEN +: XLEN]}));
  end

  assert property (@(posedge clk) pend_view[0] == 1'b0);
  assert property (@(posedge clk) (RD_PORTS <= SCR1_MPRF_MAX_RD) && (WR_PORTS <= SCR1_MPRF_MAX_WR));
`endif

endmodule

// File: tb/tb_scr1_pipe_mprf_mp.sv
// Directed bench for scr1_pipe_mprf_mp: behavioural model checked every cycle plus literal pins.
module tb_scr1_pipe_mprf_mp;
  import scr1_mprf_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RD    = 2;
  localparam int WR    = 2;
  localparam int BYP   = 1;
  localparam int AW    = scr1_mprf_aw(NREGS);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scr1_pipe_mprf_mp_if #(.XLEN(XLEN), .AW(AW), .RD_PORTS(RD), .WR_PORTS(WR)) bus ();

  scr1_pipe_mprf_mp #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .RD_PORTS  (RD),
    .WR_PORTS  (WR),
    .BYPASS_EN (BYP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   total  = 0;
  int   bad    = 0;
  bit   chk_en = 1'b0;

  logic [31:0] m_regs [NREGS];
  bit          m_pend [NREGS];
  bit          m_coll;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model of what a read port must return given current inputs and architectural state.
  function automatic void modelRead(input int a, output logic [31:0] d, output logic pd);
    int w;
    w  = -1;
    d  = '0;
    pd = 1'b0;
    if (a != 0) begin
      for (int p = 0; p < WR; p++) begin
        if (bus.wr_req[p] && (int'(bus.wr_addr[p*AW +: AW]) == a)) w = p;
      end
      if ((BYP != 0) && (w >= 0)) begin
        d  = bus.wr_data[w*XLEN +: XLEN];
        pd = !bus.sb_flush && bus.sb_set && (int'(bus.sb_addr) == a);
      end else begin
        d  = m_regs[a];
        pd = m_pend[a];
      end
    end
  endfunction

  always @(posedge clk) begin : model_update
    int hits [NREGS];
    int a;
    for (int r = 0; r < NREGS; r++) hits[r] = 0;
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
      m_coll = 1'b0;
    end else begin
      m_coll = 1'b0;
      for (int p = 0; p < WR; p++) begin
        if (bus.wr_req[p]) begin
          a = int'(bus.wr_addr[p*AW +: AW]);
          if (a != 0) begin
            hits[a]++;
            m_regs[a] = bus.wr_data[p*XLEN +: XLEN];
          end
        end
      end
      for (int r = 1; r < NREGS; r++) begin
        if (hits[r] > 1) m_coll = 1'b1;
        if (bus.sb_flush) m_pend[r] = 1'b0;
        else if (bus.sb_set && (int'(bus.sb_addr) == r)) m_pend[r] = 1'b1;
        else if (hits[r] > 0) m_pend[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] ed;
    logic        ep;
    if (chk_en) begin
      for (int p = 0; p < RD; p++) begin
        modelRead(int'(bus.rd_addr[p*AW +: AW]), ed, ep);
        checkOutput($sformatf("rd_data%0d", p), bus.rd_data[p*XLEN +: XLEN], ed);
        checkOutput($sformatf("rd_pend%0d", p), 32'(bus.rd_pend[p]), 32'(ep));
      end
      checkOutput("wr_coll", 32'(bus.wr_coll), 32'(m_coll));
    end
  end

  // Advance to the next cycle and drive one full input vector; returns with outputs settled.
  task automatic applyStimulus(input logic rstn, input logic [1:0] req,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic sbs, input logic [4:0] sba, input logic fl,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    @(posedge clk);
    #1;
    rst_n        = rstn;
    bus.wr_req   = req;
    bus.wr_addr  = {wa1, wa0};
    bus.wr_data  = {wd1, wd0};
    bus.sb_set   = sbs;
    bus.sb_addr  = sba;
    bus.sb_flush = fl;
    bus.rd_addr  = {ra1, ra0};
    #2;
  endtask

  task automatic idleRead(input logic [4:0] ra0, input logic [4:0] ra1);
    applyStimulus(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, ra0, ra1);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    bus.wr_req = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0; bus.sb_flush = 1'b0; bus.rd_addr = '0;

    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    chk_en = 1'b1;

    // 1: cleared state everywhere
    for (int i = 1; i < NREGS; i++) begin
      idleRead(5'(i), 5'(NREGS - i));
      if (i == 31) begin
        checkOutput("t1_data0", bus.rd_data[31:0], 32'h0);
        checkOutput("t1_pend1", 32'(bus.rd_pend[1]), 32'h0);
        checkOutput("t1_coll", 32'(bus.wr_coll), 32'h0);
      end
    end

    // 2: bypass then stored value
    applyStimulus(1'b1, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
    checkOutput("t2_bypass", bus.rd_data[31:0], 32'hDEADBEEF);
    idleRead(5'd5, 5'd0);
    checkOutput("t2_stored", bus.rd_data[31:0], 32'hDEADBEEF);

    // 3: collision, higher port wins
    applyStimulus(1'b1, 2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    checkOutput("t3_bypass_win", bus.rd_data[63:32], 32'h2);
    idleRead(5'd7, 5'd0);
    checkOutput("t3_data", bus.rd_data[31:0], 32'h2);
    checkOutput("t3_coll_set", 32'(bus.wr_coll), 32'h1);
    idleRead(5'd7, 5'd0);
    checkOutput("t3_coll_clr", 32'(bus.wr_coll), 32'h0);

    // 4: scoreboard set / hold / write-clear
    applyStimulus(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
    idleRead(5'd9, 5'd0);
    idleRead(5'd9, 5'd0);
    idleRead(5'd9, 5'd0);
    checkOutput("t4_pend_set", 32'(bus.rd_pend[0]), 32'h1);
    applyStimulus(1'b1, 2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
    checkOutput("t4_pend_byp", 32'(bus.rd_pend[0]), 32'h1);
    idleRead(5'd9, 5'd0);
    checkOutput("t4_pend_hold", 32'(bus.rd_pend[0]), 32'h1);
    checkOutput("t4_data", bus.rd_data[31:0], 32'h99);
    applyStimulus(1'b1, 2'b01, 5'd9, 32'hAA, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
    checkOutput("t4_pend_byp_clr", 32'(bus.rd_pend[0]), 32'h0);
    idleRead(5'd9, 5'd0);
    checkOutput("t4_pend_clr", 32'(bus.rd_pend[0]), 32'h0);

    // 5: x0 is inert
    applyStimulus(1'b1, 2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    checkOutput("t5_x0_data", bus.rd_data[31:0], 32'h0);
    checkOutput("t5_x0_pend", 32'(bus.rd_pend[0]), 32'h0);
    applyStimulus(1'b1, 2'b11, 5'd0, 32'h1, 5'd0, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    idleRead(5'd0, 5'd0);
    checkOutput("t5_no_coll", 32'(bus.wr_coll), 32'h0);

    // 6: flush with write, then reset
    applyStimulus(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd4);
    applyStimulus(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd3, 5'd4);
    idleRead(5'd3, 5'd4);
    checkOutput("t6_pend3", 32'(bus.rd_pend[0]), 32'h1);
    checkOutput("t6_pend4", 32'(bus.rd_pend[1]), 32'h1);
    applyStimulus(1'b1, 2'b10, 5'd0, 32'h0, 5'd3, 32'h55, 1'b0, 5'd0, 1'b1, 5'd3, 5'd4);
    checkOutput("t6_flush_byp", bus.rd_data[31:0], 32'h55);
    checkOutput("t6_flush_x4_old", 32'(bus.rd_pend[1]), 32'h1);
    idleRead(5'd3, 5'd4);
    checkOutput("t6_x3", bus.rd_data[31:0], 32'h55);
    checkOutput("t6_pend3_clr", 32'(bus.rd_pend[0]), 32'h0);
    checkOutput("t6_pend4_clr", 32'(bus.rd_pend[1]), 32'h0);
    applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd5);
    idleRead(5'd3, 5'd5);
    checkOutput("t6_rst_x3", bus.rd_data[31:0], 32'h0);
    checkOutput("t6_rst_x5", bus.rd_data[63:32], 32'h0);

    // Mixed traffic on a few registers to stress collisions and scoreboard interplay.
    for (int i = 0; i < 60; i++) begin
      logic fl;
      fl = ($urandom_range(0, 9) == 0);
      applyStimulus(1'b1, 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 5)), $urandom,
                    5'($urandom_range(0, 5)), $urandom,
                    fl ? 1'b0 : 1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)), fl,
                    5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)));
    end
    idleRead(5'd1, 5'd2);
    idleRead(5'd3, 5'd4);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
